// File: rtl/game_pkg.sv
// Shared game constants and state encoding for the supervisor, bird and pipe blocks.
// Optional high-score tracking is controlled by GAME_HIGH_SCORE_EN.
package game_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_DEAD = 2'd2;
  localparam logic [1:0] ST_OVER = 2'd3;

  localparam int GROUND_Y    = 668;
  localparam int BIRD_W      = 34;
  localparam int BIRD_H      = 35;
  localparam int PIPE_W      = 80;
  localparam int GAP_H       = 200;
  localparam int DEAD_FRAMES = 60;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_PLAY = ST_PLAY,
    S_DEAD = ST_DEAD,
    S_OVER = ST_OVER
  } state_e;

  // Digit-wise compare, most significant digit decides first.
  function automatic logic bcd_gt(input logic [11:0] a, input logic [11:0] b);
    logic res;
    logic done;
    res  = 1'b0;
    done = 1'b0;
    for (int i = 2; i >= 0; i--) begin
      if (!done && (a[i*4 +: 4] != b[i*4 +: 4])) begin
        res  = (a[i*4 +: 4] > b[i*4 +: 4]);
        done = 1'b1;
      end
    end
    return res;
  endfunction
endpackage

// File: rtl/game_state_ctrl_if.sv
// Bird/pipe inputs and game status outputs of the game supervisor.
// GAME_HIGH_SCORE_EN adds the best_bcd signal.
interface game_state_ctrl_if;
  logic        frame_tick;
  logic        key_start;
  logic [11:0] bird_x;
  logic [11:0] bird_y;
  logic [11:0] pipe_x;
  logic [11:0] pipe_gap_y;
  logic        game_active;
  logic        game_over;
  logic [1:0]  state;
  logic        collide;
  logic [11:0] score_bcd;
`ifdef GAME_HIGH_SCORE_EN
  logic [11:0] best_bcd;
`endif

  modport master (
    output frame_tick, key_start, bird_x, bird_y, pipe_x, pipe_gap_y,
    input  game_active, game_over, state, collide, score_bcd
`ifdef GAME_HIGH_SCORE_EN
    , input best_bcd
`endif
  );

  modport slave (
    input  frame_tick, key_start, bird_x, bird_y, pipe_x, pipe_gap_y,
    output game_active, game_over, state, collide, score_bcd
`ifdef GAME_HIGH_SCORE_EN
    , output best_bcd
`endif
  );
endinterface

// File: rtl/bcd_counter3.sv
// Three-digit BCD counter with synchronous clear and increment, saturating at 999.
module bcd_counter3 (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  output logic [11:0] q
);
  logic [11:0] q_nx;

  always_comb begin
    q_nx = q;
    if (q != 12'h999) begin
      if (q[3:0] != 4'd9) begin
        q_nx[3:0] = q[3:0] + 4'd1;
      end else begin
        q_nx[3:0] = 4'd0;
        if (q[7:4] != 4'd9) begin
          q_nx[7:4] = q[7:4] + 4'd1;
        end else begin
          q_nx[7:4]  = 4'd0;
          q_nx[11:8] = q[11:8] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      q <= '0;
    else if (clr) q <= '0;
    else if (inc) q <= q_nx;
  end
endmodule

// File: rtl/game_state_ctrl.sv
// Game supervisor: per-frame collision checks, BCD score and IDLE/PLAY/DEAD/OVER sequencing.
// Define GAME_HIGH_SCORE_EN to add best_bcd tracking.
module game_state_ctrl
  import game_pkg::*;
(
  input logic              clk,
  input logic              rst,
  game_state_ctrl_if.slave gif
);
  logic key_s1, key_s2, key_s3, key_edge;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_s1 <= 1'b0;
      key_s2 <= 1'b0;
      key_s3 <= 1'b0;
    end else begin
      key_s1 <= gif.key_start;
      key_s2 <= key_s1;
      key_s3 <= key_s2;
    end
  end

  assign key_edge = key_s2 & ~key_s3;

  // All geometry sums carried in 13 bits so none of them can wrap.
  logic [12:0] bird_l, bird_r, bird_t, bird_b, pipe_l, pipe_r, gap_t, gap_b;
  logic        hit_ground, hit_ceil, hit_pipe, hit, cleared;

  assign bird_l = {1'b0, gif.bird_x};
  assign bird_r = bird_l + 13'(BIRD_W);
  assign bird_t = {1'b0, gif.bird_y};
  assign bird_b = bird_t + 13'(BIRD_H);
  assign pipe_l = {1'b0, gif.pipe_x};
  assign pipe_r = pipe_l + 13'(PIPE_W);
  assign gap_t  = {1'b0, gif.pipe_gap_y};
  assign gap_b  = gap_t + 13'(GAP_H);

  assign hit_ground = (bird_b >= 13'(GROUND_Y));
  assign hit_ceil   = (gif.bird_y == 12'd0);
  assign hit_pipe   = (bird_r > pipe_l) && (bird_l < pipe_r) &&
                      ((bird_t < gap_t) || (bird_b > gap_b));
  assign hit        = hit_ground | hit_ceil | hit_pipe;
  assign cleared    = (pipe_r < bird_l);

  state_e      state_q, state_d;
  logic [5:0]  dead_q, dead_d;
  logic        passed_q, passed_d;
  logic        score_clr, score_inc, collide_d;
  logic        active_q, over_q, collide_q;
  logic [11:0] score;

  always_comb begin
    state_d   = state_q;
    dead_d    = dead_q;
    passed_d  = passed_q;
    score_clr = 1'b0;
    score_inc = 1'b0;
    collide_d = 1'b0;
    case (state_q)
      S_IDLE: if (key_edge) begin
        state_d   = S_PLAY;
        score_clr = 1'b1;
        passed_d  = 1'b0;
      end
      S_PLAY: if (gif.frame_tick) begin
        if (hit) begin
          state_d   = S_DEAD;
          collide_d = 1'b1;
          dead_d    = '0;
        end else if (cleared) begin
          if (!passed_q) begin
            score_inc = 1'b1;
            passed_d  = 1'b1;
          end
        end else begin
          passed_d = 1'b0;
        end
      end
      S_DEAD: if (gif.frame_tick) begin
        if (dead_q == 6'(DEAD_FRAMES - 1)) begin
          state_d = S_OVER;
          dead_d  = '0;
        end else begin
          dead_d = dead_q + 6'd1;
        end
      end
      S_OVER: if (key_edge) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      dead_q    <= '0;
      passed_q  <= 1'b0;
      active_q  <= 1'b0;
      over_q    <= 1'b0;
      collide_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dead_q    <= dead_d;
      passed_q  <= passed_d;
      active_q  <= (state_d == S_PLAY);
      over_q    <= (state_d == S_OVER);
      collide_q <= collide_d;
    end
  end

  bcd_counter3 u_score (
    .clk (clk),
    .rst (rst),
    .clr (score_clr),
    .inc (score_inc),
    .q   (score)
  );

  assign gif.state       = state_q;
  assign gif.game_active = active_q;
  assign gif.game_over   = over_q;
  assign gif.collide     = collide_q;
  assign gif.score_bcd   = score;

`ifdef GAME_HIGH_SCORE_EN
  logic [11:0] best_q;

  // Score is frozen in DEAD, so the value at OVER entry is the final score.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) best_q <= '0;
    else if (state_q == S_DEAD && state_d == S_OVER && bcd_gt(score, best_q))
      best_q <= score;
  end

  assign gif.best_bcd = best_q;
`endif
endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl with a cycle-level behavioural model compared every cycle.
module tb_game_state_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  game_state_ctrl_if gif ();

  game_state_ctrl dut (
    .clk (clk),
    .rst (rst),
    .gif (gif)
  );

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Behavioural model: integer score, integer state, key history of raw samples.
  int m_st, m_score, m_best, m_dead;
  bit m_passed, m_coll, k1, k2, k3;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_st = 0; m_score = 0; m_best = 0; m_dead = 0;
      m_passed = 0; m_coll = 0; k1 = 0; k2 = 0; k3 = 0;
    end else begin
      bit kedge, hit, clr_p;
      int bx, by, px, gy;
      kedge = k2 && !k3;
      k3 = k2; k2 = k1; k1 = gif.key_start;
      bx = int'(gif.bird_x); by = int'(gif.bird_y);
      px = int'(gif.pipe_x); gy = int'(gif.pipe_gap_y);
      hit = (by + 35 >= 668) || (by == 0) ||
            ((bx + 34 > px) && (bx < px + 80) && ((by < gy) || (by + 35 > gy + 200)));
      clr_p = (px + 80 < bx);
      m_coll = 0;
      case (m_st)
        0: if (kedge) begin m_st = 1; m_score = 0; m_passed = 0; end
        1: if (gif.frame_tick) begin
          if (hit) begin m_st = 2; m_coll = 1; m_dead = 0; end
          else if (clr_p) begin
            if (!m_passed) begin
              if (m_score < 999) m_score++;
              m_passed = 1;
            end
          end else m_passed = 0;
        end
        2: if (gif.frame_tick) begin
          if (m_dead == 59) begin
            m_st = 3; m_dead = 0;
            if (m_score > m_best) m_best = m_score;
          end else m_dead++;
        end
        default: if (kedge) m_st = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("state", 32'(gif.state), 32'(m_st));
      chk("game_active", 32'(gif.game_active), 32'(m_st == 1));
      chk("game_over", 32'(gif.game_over), 32'(m_st == 3));
      chk("collide", 32'(gif.collide), 32'(m_coll));
      chk("score_bcd", 32'(gif.score_bcd), 32'(to_bcd(m_score)));
`ifdef GAME_HIGH_SCORE_EN
      chk("best_bcd", 32'(gif.best_bcd), 32'(to_bcd(m_best)));
`endif
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick();
    @(negedge clk) gif.frame_tick = 1'b1;
    @(negedge clk) gif.frame_tick = 1'b0;
  endtask

  task automatic press();
    @(negedge clk) gif.key_start = 1'b1;
    cyc(4);
    gif.key_start = 1'b0;
    cyc(4);
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(1);
  endtask

  task automatic safe_pos();
    gif.bird_x = 12'd300; gif.bird_y = 12'd300;
    gif.pipe_x = 12'd1024; gif.pipe_gap_y = 12'd250;
  endtask

  task automatic pass_pipe();
    gif.pipe_x = 12'd219; tick();
    gif.pipe_x = 12'd1024; tick();
  endtask

  task automatic die_to_over();
    gif.bird_y = 12'd634; tick();
    gif.bird_y = 12'd300;
    repeat (60) tick();
  endtask

  initial begin
    gif.frame_tick = 1'b0; gif.key_start = 1'b0;
    safe_pos();
    cyc(3);
    rst = 1'b0;
    cyc(1);
    // T1: reset state, then start
    chk("rst_state", 32'(gif.state), 32'd0);
    chk("rst_score", 32'(gif.score_bcd), 32'h000);
`ifdef GAME_HIGH_SCORE_EN
    chk("rst_best", 32'(gif.best_bcd), 32'h000);
`endif
    @(negedge clk) gif.key_start = 1'b1;
    cyc(2);
    chk("start_not_yet", 32'(gif.state), 32'd0);
    cyc(1);
    chk("start_play", 32'(gif.state), 32'd1);
    chk("start_active", 32'(gif.game_active), 32'd1);
    cyc(3);
    gif.key_start = 1'b0;
    cyc(3);
    // T2: ground boundary; hit beats a simultaneous score event
    gif.bird_y = 12'd632; tick();
    chk("ground_632", 32'(gif.state), 32'd1);
    gif.bird_y = 12'd634; gif.pipe_x = 12'd219; tick();
    chk("ground_634", 32'(gif.state), 32'd2);
    chk("collide_pulse", 32'(gif.collide), 32'd1);
    chk("hit_wins", 32'(gif.score_bcd), 32'h000);
    cyc(1);
    chk("collide_clear", 32'(gif.collide), 32'd0);
    // T5: DEAD for exactly 60 ticks, then two presses restart
    safe_pos();
    press();
    chk("dead_key_ignored", 32'(gif.state), 32'd2);
    repeat (59) tick();
    chk("dead_59", 32'(gif.state), 32'd2);
    tick();
    chk("over_60", 32'(gif.state), 32'd3);
    chk("over_flag", 32'(gif.game_over), 32'd1);
    press();
    chk("over_to_idle", 32'(gif.state), 32'd0);
    press();
    chk("idle_to_play", 32'(gif.state), 32'd1);
    // T3: pipe overlap in gap, then below gap
    gif.pipe_x = 12'd290; gif.pipe_gap_y = 12'd300; gif.bird_y = 12'd350;
    tick();
    chk("pipe_in_gap", 32'(gif.state), 32'd1);
    gif.bird_y = 12'd470; tick();
    chk("pipe_hit", 32'(gif.state), 32'd2);
    // ceiling
    do_reset();
    safe_pos();
    press();
    gif.bird_y = 12'd0; tick();
    chk("ceiling_hit", 32'(gif.state), 32'd2);
    // T4: scoring once per pipe, then saturation
    do_reset();
    safe_pos();
    press();
    for (int p = 250; p >= 219; p--) begin
      gif.pipe_x = 12'(p);
      tick();
      if (p == 220) chk("score_before_clear", 32'(gif.score_bcd), 32'h000);
    end
    repeat (3) tick();
    chk("score_001", 32'(gif.score_bcd), 32'h001);
    gif.pipe_x = 12'd1024; tick();
    for (int p = 250; p >= 219; p--) begin
      gif.pipe_x = 12'(p);
      tick();
    end
    chk("score_002", 32'(gif.score_bcd), 32'h002);
    gif.pipe_x = 12'd1024; tick();
    for (int i = 0; i < 7; i++) pass_pipe();
    chk("score_009", 32'(gif.score_bcd), 32'h009);
    pass_pipe();
    chk("score_010", 32'(gif.score_bcd), 32'h010);
    for (int i = 0; i < 989; i++) pass_pipe();
    chk("score_999", 32'(gif.score_bcd), 32'h999);
    pass_pipe();
    chk("score_sat", 32'(gif.score_bcd), 32'h999);
    // T6: async reset in PLAY with score 005
    do_reset();
    safe_pos();
    press();
    repeat (5) pass_pipe();
    chk("score_005", 32'(gif.score_bcd), 32'h005);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_state", 32'(gif.state), 32'd0);
    chk("async_active", 32'(gif.game_active), 32'd0);
    chk("async_score", 32'(gif.score_bcd), 32'h000);
    cyc(2);
    rst = 1'b0;
    cyc(1);
    // full 005 game to OVER
    press();
    repeat (5) pass_pipe();
    die_to_over();
    chk("final_over", 32'(gif.state), 32'd3);
    chk("final_score", 32'(gif.score_bcd), 32'h005);
`ifdef GAME_HIGH_SCORE_EN
    chk("best_005", 32'(gif.best_bcd), 32'h005);
`endif
    press();
    chk("idle_keeps_score", 32'(gif.score_bcd), 32'h005);
    press();
    chk("new_game_clear", 32'(gif.score_bcd), 32'h000);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
